// File: rtl/md_pkg.sv
// md_pkg - shared definitions for the E-stage iterative multiply/divide unit.
//   Opcode encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), controller state
//   encodings (ST_IDLE, ST_RUN, ST_FIX), the default operand width and the
//   iteration count / counter width defaults.
package md_pkg;

  localparam int MD_WIDTH = 32;        // default operand width
  localparam int MD_ITER  = MD_WIDTH;  // one iteration per operand bit
  localparam int MD_CNT_W = 6;         // 2**MD_CNT_W must exceed MD_ITER

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/e_md_signfix.sv
// e_md_signfix - combinational sign correction for the iterative MD engine.
//   The iteration runs on magnitudes; this block turns the raw unsigned
//   {hi,lo} into the architectural signed result.
// Ports:
//   raw_hi, raw_lo  in   unsigned product halves / remainder,quotient
//   op              in   opcode of the operation being finished
//   sign_a, sign_b  in   operand signs (already zero for unsigned ops)
//   fix_hi, fix_lo  out  sign-corrected {hi,lo}
module e_md_signfix
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] raw_hi,
  input  logic [WIDTH-1:0] raw_lo,
  input  md_op_e           op,
  input  logic             sign_a,
  input  logic             sign_b,
  output logic [WIDTH-1:0] fix_hi,
  output logic [WIDTH-1:0] fix_lo
);

  logic [2*WIDTH-1:0] prod_neg;
  assign prod_neg = -{raw_hi, raw_lo};

  always_comb begin
    fix_hi = raw_hi;
    fix_lo = raw_lo;
    case (op)
      MD_MULT: begin
        if (sign_a ^ sign_b) begin
          {fix_hi, fix_lo} = prod_neg;
        end
      end
      MD_DIV: begin
        // Quotient sign is the xor of the operand signs; the remainder
        // follows the dividend.
        if (sign_a ^ sign_b) begin
          fix_lo = -raw_lo;
        end
        if (sign_a) begin
          fix_hi = -raw_hi;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_md_iter.sv
// e_md_iter - iterative radix-2 multiply / restoring divide engine.
//   start is accepted only in IDLE; the engine then runs WIDTH iterations
//   (RUN) on operand magnitudes and applies signs in FIX. done pulses for
//   one cycle when hi/lo are updated; start-to-done latency is WIDTH+2.
//   Division by zero yields lo=all ones, hi=dividend as presented.
// Optional build macro: MD_EARLY_OUT_EN - multiplies with a zero operand and
//   divides by zero finish at the first RUN edge (done two cycles after
//   start). Without it every operation takes the full latency.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start, op      one-cycle request and opcode (0 mult,1 multu,2 div,3 divu)
//   src_a, src_b   multiplicand/dividend, multiplier/divisor
//   cancel         abort in RUN/FIX, no done, hi/lo untouched
//   busy, done     busy while an operation is in flight; done pulse
//   hi, lo         result: product high/low or remainder/quotient
module e_md_iter
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               divzero_q, divzero_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   src_a_q, src_a_d;   // dividend as presented, for /0
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
`ifdef MD_EARLY_OUT_EN
  logic               early_q, early_d;
`endif

  // Request decode
  logic             in_signed, in_is_div, in_sign_a, in_sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign in_signed = (op == 2'(MD_MULT)) || (op == 2'(MD_DIV));
  assign in_is_div = op[1];
  assign in_sign_a = in_signed & src_a[WIDTH-1];
  assign in_sign_b = in_signed & src_b[WIDTH-1];
  assign mag_a     = in_sign_a ? -src_a : src_a;
  assign mag_b     = in_sign_b ? -src_b : src_b;

  // Multiply step: acc = {partial, multiplier}; add on multiplier LSB,
  // then shift right keeping the carry out of the add.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: acc = {rem, quot}. The shifted remainder needs one extra
  // bit because it can reach twice the divisor before the compare.
  logic [WIDTH:0]     rem_sh, rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_ge   = rem_sh >= {1'b0, opnd_q};
  assign rem_sub  = rem_sh - {1'b0, opnd_q};
  assign div_next = rem_ge ? {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};

  logic op_is_div;
  assign op_is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);

  logic [WIDTH-1:0] fix_hi, fix_lo, res_hi, res_lo;

  e_md_signfix #(.WIDTH(WIDTH)) u_signfix (
    .raw_hi (acc_q[2*WIDTH-1:WIDTH]),
    .raw_lo (acc_q[WIDTH-1:0]),
    .op     (op_q),
    .sign_a (sign_a_q),
    .sign_b (sign_b_q),
    .fix_hi (fix_hi),
    .fix_lo (fix_lo)
  );

  // Division by zero overrides whatever the iteration produced.
  assign res_hi = divzero_q ? src_a_q : fix_hi;
  assign res_lo = divzero_q ? '1      : fix_lo;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    divzero_d = divzero_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    src_a_d   = src_a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef MD_EARLY_OUT_EN
    early_d   = early_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // start beats cancel here; cancel alone is a no-op in IDLE.
        if (start) begin
          op_d      = md_op_e'(op);
          sign_a_d  = in_sign_a;
          sign_b_d  = in_sign_b;
          src_a_d   = src_a;
          divzero_d = in_is_div && (src_b == '0);
          cnt_d     = CNT_W'(WIDTH);
          opnd_d    = in_is_div ? mag_b : mag_a;
          acc_d     = {{WIDTH{1'b0}}, (in_is_div ? mag_a : mag_b)};
          state_d   = ST_RUN;
`ifdef MD_EARLY_OUT_EN
          early_d   = in_is_div ? (src_b == '0)
                                : ((src_a == '0) || (src_b == '0));
`endif
        end
      end
      ST_RUN: begin
        if (cancel) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
`ifdef MD_EARLY_OUT_EN
        else if (early_q) begin
          // Only two cases reach here: zero product or division by zero.
          hi_d    = divzero_q ? src_a_q : '0;
          lo_d    = divzero_q ? '1 : '0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
`endif
        else begin
          acc_d = op_is_div ? div_next : mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        if (!cancel) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= MD_MULT;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      divzero_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      src_a_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MD_EARLY_OUT_EN
      early_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      divzero_q <= divzero_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      src_a_q   <= src_a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef MD_EARLY_OUT_EN
      early_q   <= early_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
